// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped cache line controller.
// Address layout, from MSB to LSB: tag | index | word offset.
package cache_pkg;

  localparam int DEF_ADDR_WIDTH   = 16;
  localparam int DEF_BLCK_ADDR    = 4;
  localparam int DEF_NUM_OF_WORDS = 16;
  localparam int DEF_WORD_SIZE    = 16;
  localparam int DEF_LINE_ADDR    = 3;

  localparam int TAG_W        = DEF_ADDR_WIDTH - DEF_LINE_ADDR - DEF_BLCK_ADDR;
  localparam int NUM_OF_LINES = 2 ** DEF_LINE_ADDR;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MEM_WRITE,
    ST_REFILL,
    ST_DONE
  } state_t;

  function automatic logic [DEF_BLCK_ADDR-1:0] addr_offset(input logic [DEF_ADDR_WIDTH-1:0] a);
    return a[DEF_BLCK_ADDR-1:0];
  endfunction

  function automatic logic [DEF_LINE_ADDR-1:0] addr_index(input logic [DEF_ADDR_WIDTH-1:0] a);
    return a[DEF_BLCK_ADDR +: DEF_LINE_ADDR];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [DEF_ADDR_WIDTH-1:0] a);
    return a[DEF_ADDR_WIDTH-1 -: TAG_W];
  endfunction

  function automatic logic [DEF_ADDR_WIDTH-1:0] line_base(input logic [DEF_ADDR_WIDTH-1:0] a);
    return {a[DEF_ADDR_WIDTH-1:DEF_BLCK_ADDR], {DEF_BLCK_ADDR{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Valid/tag arrays for every line: combinational hit on the addressed index, write on fill.
// Valid bits clear asynchronously on reset; tag contents are meaningless until their valid bit is set.
module cache_tag_store
  import cache_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DEF_LINE_ADDR-1:0] index,
  input  logic [TAG_W-1:0]         tag,
  input  logic                     fill_en,
  output logic                     hit
);

  logic [NUM_OF_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]        tag_q [NUM_OF_LINES];
  logic [TAG_W-1:0]        tag_d [NUM_OF_LINES];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (fill_en) begin
      valid_d[index] = 1'b1;
      tag_d[index]   = tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  assign hit = valid_q[index] && (tag_q[index] == tag);

endmodule

// File: rtl/cache_line_controller.sv
// Direct-mapped write-through, no-write-allocate controller sequencing external line blocks.
// Read hit 2 cycles after accept; misses and writes wait on mem_ack; CACHE_STATS_EN adds hit/miss counters.
module cache_line_controller
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int BLCK_ADDR    = DEF_BLCK_ADDR,
  parameter int NUM_OF_WORDS = DEF_NUM_OF_WORDS,
  parameter int WORD_SIZE    = DEF_WORD_SIZE,
  parameter int LINE_ADDR    = DEF_LINE_ADDR
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cpu_req,
  input  logic                              cpu_we,
  input  logic [ADDR_WIDTH-1:0]             cpu_addr,
  input  logic [WORD_SIZE-1:0]              cpu_wdata,
  output logic [WORD_SIZE-1:0]              cpu_rdata,
  output logic                              cpu_ready,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [WORD_SIZE-1:0]              mem_wdata,
  input  logic [WORD_SIZE*NUM_OF_WORDS-1:0] mem_rdata,
  input  logic                              mem_ack,
  output logic [LINE_ADDR-1:0]              line_sel,
  output logic [BLCK_ADDR-1:0]              blk_r_addr,
  input  logic [WORD_SIZE-1:0]              blk_q,
  output logic [WORD_SIZE*NUM_OF_WORDS-1:0] blk_w_block_data,
  output logic [WORD_SIZE-1:0]              blk_w_word_data,
  output logic                              blk_block_ready,
  output logic                              blk_new_word,
  output logic                              blk_new_block
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                       hit_count,
  output logic [31:0]                       miss_count
`endif
);

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WORD_SIZE-1:0]    wdata_q, wdata_d;
  logic [WORD_SIZE-1:0]    rdata_q, rdata_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic                    hit;
  logic                    fill_en;

  assign fill_en = (state_q == ST_REFILL) && mem_ack;

  cache_tag_store u_tag_store (
    .clk     (clk),
    .rst     (rst),
    .index   (addr_index(addr_q)),
    .tag     (addr_tag(addr_q)),
    .fill_en (fill_en),
    .hit     (hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (cpu_req) state_d = ST_LOOKUP;
      ST_LOOKUP:    state_d = we_q ? ST_MEM_WRITE : (hit ? ST_DONE : ST_REFILL);
      ST_MEM_WRITE: if (mem_ack) state_d = ST_DONE;
      ST_REFILL:    if (mem_ack) state_d = ST_LOOKUP;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Memory handshake flops follow the next state so they drop the cycle after mem_ack.
  always_comb begin
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    mem_req_d = (state_d == ST_MEM_WRITE) || (state_d == ST_REFILL);
    mem_we_d  = (state_d == ST_MEM_WRITE);
    if (state_q == ST_IDLE && cpu_req) begin
      we_d    = cpu_we;
      addr_d  = cpu_addr;
      wdata_d = cpu_wdata;
    end
    if (state_q == ST_LOOKUP && hit && !we_q) begin
      rdata_d = blk_q;
    end
  end

  always_comb begin
    cpu_ready        = (state_q == ST_DONE);
    cpu_rdata        = rdata_q;
    mem_req          = mem_req_q;
    mem_we           = mem_we_q;
    mem_addr         = '0;
    if (mem_req_q) mem_addr = mem_we_q ? addr_q : line_base(addr_q);
    mem_wdata        = wdata_q;
    line_sel         = addr_index(addr_q);
    blk_r_addr       = addr_offset(addr_q);
    blk_w_word_data  = wdata_q;
    blk_new_word     = (state_q == ST_LOOKUP) && we_q && hit;
    blk_block_ready  = blk_new_word;
    blk_new_block    = fill_en;
    blk_w_block_data = fill_en ? mem_rdata : '0;
  end

`ifdef CACHE_STATS_EN
  // A refill loops back into LOOKUP; only the first lookup of a request is counted.
  logic        revisit_q, revisit_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        first_lookup;

  assign first_lookup = (state_q == ST_LOOKUP) && !revisit_q;

  always_comb begin
    revisit_d  = revisit_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == ST_IDLE && cpu_req) revisit_d = 1'b0;
    if (fill_en) revisit_d = 1'b1;
    if (first_lookup && hit && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
    if (first_lookup && !hit && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      revisit_q  <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      revisit_q  <= revisit_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
